// File: rtl/reservation_station_param.sv
// reservation_station_param
//   Out-of-order issue buffer. Each entry holds an operation waiting for its
//   two source operands. Operands are captured from the forwarding buses at
//   insert time or later by wake-up. The oldest entry whose operands are both
//   present is offered for issue.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : discard every entry; blocks insert, issue and wake-up
//   inValid/inReady   : insert handshake (inReady = a slot is free)
//   inOp, inRob       : opcode and destination ROB tag
//   inWaitA/B, inTagA/B, inValA/B : operand state at insert time
//   fwdValid/Tag/Data : NUM_FWD result buses, bus k at [k*W +: W]
//   outValid/outReady : issue handshake
//   outOperation      : {op, rob, valA, valB} of the selected entry
//   count             : number of occupied entries
module reservation_station_param #(
    parameter int DEPTH   = 8,
    parameter int NUM_FWD = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 16,
    parameter int OP_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic [OP_W-1:0]             inOp,
    input  logic [TAG_W-1:0]            inRob,
    input  logic                        inWaitA,
    input  logic                        inWaitB,
    input  logic [TAG_W-1:0]            inTagA,
    input  logic [TAG_W-1:0]            inTagB,
    input  logic [DATA_W-1:0]           inValA,
    input  logic [DATA_W-1:0]           inValB,
    input  logic [NUM_FWD-1:0]          fwdValid,
    input  logic [NUM_FWD*TAG_W-1:0]    fwdTag,
    input  logic [NUM_FWD*DATA_W-1:0]   fwdData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic [OP_W+TAG_W+2*DATA_W-1:0] outOperation,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  occ;
    logic [DEPTH-1:0]  wait_a;
    logic [DEPTH-1:0]  wait_b;
    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [TAG_W-1:0]  rob_q  [DEPTH];
    logic [TAG_W-1:0]  tag_a  [DEPTH];
    logic [TAG_W-1:0]  tag_b  [DEPTH];
    logic [DATA_W-1:0] val_a  [DEPTH];
    logic [DATA_W-1:0] val_b  [DEPTH];
    // older[j][i] = 1 means entry j was inserted before entry i.
    logic [DEPTH-1:0]  older  [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  blocked;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  ins_idx;
    logic [DATA_W:0]   lk_a   [DEPTH];
    logic [DATA_W:0]   lk_b   [DEPTH];
    logic [DATA_W:0]   lk_in_a;
    logic [DATA_W:0]   lk_in_b;
    logic              do_ins;
    logic              do_iss;

    // Returns {hit, data}; scanning downwards lets the lowest bus win.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_FWD-1:0]        v,
        input logic [NUM_FWD*TAG_W-1:0]  t,
        input logic [NUM_FWD*DATA_W-1:0] d
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (v[k] && (t[k*TAG_W +: TAG_W] == tag))
                r = {1'b1, d[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lk_a[i] = fwd_lookup(tag_a[i], fwdValid, fwdTag, fwdData);
            lk_b[i] = fwd_lookup(tag_b[i], fwdValid, fwdTag, fwdData);
        end
        lk_in_a = fwd_lookup(inTagA, fwdValid, fwdTag, fwdData);
        lk_in_b = fwd_lookup(inTagB, fwdValid, fwdTag, fwdData);
    end

    // Oldest-ready select: an entry is chosen when no older entry is ready.
    always_comb begin
        ready   = occ & ~wait_a & ~wait_b;
        blocked = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j][i])
                    blocked[i] = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !blocked[i])
                sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        ins_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!occ[i])
                ins_idx = IDX_W'(i);
        end
    end

    assign inReady      = (count_q < CNT_W'(DEPTH));
    assign outValid     = (|ready) && !flush;
    assign outOperation = {op_q[sel_idx], rob_q[sel_idx], val_a[sel_idx], val_b[sel_idx]};
    assign count        = count_q;
    assign do_ins       = inValid && inReady && !flush;
    assign do_iss       = outValid && outReady;

    // Control state: occupancy, wait bits, age matrix, count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                older[i] <= '0;
        end else if (flush) begin
            occ     <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i] && wait_a[i] && lk_a[i][DATA_W])
                    wait_a[i] <= 1'b0;
                if (occ[i] && wait_b[i] && lk_b[i][DATA_W])
                    wait_b[i] <= 1'b0;
            end
            if (do_iss)
                occ[sel_idx] <= 1'b0;
            if (do_ins) begin
                occ[ins_idx]    <= 1'b1;
                wait_a[ins_idx] <= inWaitA && !lk_in_a[DATA_W];
                wait_b[ins_idx] <= inWaitB && !lk_in_b[DATA_W];
                for (int j = 0; j < DEPTH; j++)
                    older[j][ins_idx] <= 1'b1;
                // Row write after the column loop clears the self bit too.
                older[ins_idx] <= '0;
            end
            count_q <= count_q + CNT_W'(do_ins) - CNT_W'(do_iss);
        end
    end

    // Payload needs no reset; occupancy qualifies everything read from it.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i] && wait_a[i] && lk_a[i][DATA_W])
                    val_a[i] <= lk_a[i][DATA_W-1:0];
                if (occ[i] && wait_b[i] && lk_b[i][DATA_W])
                    val_b[i] <= lk_b[i][DATA_W-1:0];
            end
            if (do_ins) begin
                op_q[ins_idx]  <= inOp;
                rob_q[ins_idx] <= inRob;
                tag_a[ins_idx] <= inTagA;
                tag_b[ins_idx] <= inTagB;
                val_a[ins_idx] <= (inWaitA && lk_in_a[DATA_W]) ? lk_in_a[DATA_W-1:0] : inValA;
                val_b[ins_idx] <= (inWaitB && lk_in_b[DATA_W]) ? lk_in_b[DATA_W-1:0] : inValB;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station_param.sv
module tb_reservation_station_param;
    localparam int DEPTH = 4, NUM_FWD = 2, TAG_W = 6, DATA_W = 16, OP_W = 4;
    localparam int OPER_W = OP_W + TAG_W + 2*DATA_W;

    logic clk, rst_n, flush, inValid, inReady;
    logic [OP_W-1:0] inOp;
    logic [TAG_W-1:0] inRob, inTagA, inTagB;
    logic inWaitA, inWaitB;
    logic [DATA_W-1:0] inValA, inValB;
    logic [NUM_FWD-1:0] fwdValid;
    logic [NUM_FWD*TAG_W-1:0] fwdTag;
    logic [NUM_FWD*DATA_W-1:0] fwdData;
    logic outValid, outReady;
    logic [OPER_W-1:0] outOperation;
    logic [2:0] count;

    int tests = 0, errors = 0;
    logic [OPER_W-1:0] sb [$];

    reservation_station_param #(.DEPTH(DEPTH), .NUM_FWD(NUM_FWD), .TAG_W(TAG_W),
                                .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inValid(inValid), .inReady(inReady),
        .inOp(inOp), .inRob(inRob), .inWaitA(inWaitA), .inWaitB(inWaitB),
        .inTagA(inTagA), .inTagB(inTagB), .inValA(inValA), .inValB(inValB),
        .fwdValid(fwdValid), .fwdTag(fwdTag), .fwdData(fwdData),
        .outValid(outValid), .outReady(outReady), .outOperation(outOperation),
        .count(count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OPER_W-1:0] mk(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                                             input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return {op, rob, a, b};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_insert(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                              input logic wa, input logic [TAG_W-1:0] ta, input logic [DATA_W-1:0] va,
                              input logic wb, input logic [TAG_W-1:0] tb, input logic [DATA_W-1:0] vb);
        inValid = 1'b1; inOp = op; inRob = rob;
        inWaitA = wa; inTagA = ta; inValA = va;
        inWaitB = wb; inTagB = tb; inValB = vb;
    endtask

    task automatic do_insert(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] rob,
                             input logic wa, input logic [TAG_W-1:0] ta, input logic [DATA_W-1:0] va,
                             input logic wb, input logic [TAG_W-1:0] tb, input logic [DATA_W-1:0] vb);
        set_insert(op, rob, wa, ta, va, wb, tb, vb);
        tick();
        inValid = 1'b0;
    endtask

    // Waits (bounded) for an issue, scores it against the queue head, accepts it.
    task automatic take_issue(input string name);
        logic [OPER_W-1:0] exp;
        int n = 0;
        while (!outValid && n < 20) begin tick(); n++; end
        tests++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s: issue with empty scoreboard, got %h", name, outOperation);
        end else if (!outValid) begin
            errors++; exp = sb.pop_front();
            $display("FAIL %s: timeout, outValid=0, required issue %h", name, exp);
        end else begin
            exp = sb.pop_front();
            if (outOperation !== exp) begin
                errors++; $display("FAIL %s: outOperation=%h required %h", name, outOperation, exp);
            end
            outReady = 1'b1;
            tick();
            outReady = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        tests++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b required 1", inReady); end
        tests++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b required 0", outValid); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            do_insert(4'(i), 6'(i), 1'b0, 6'd0, 16'(16'h100 + i), 1'b0, 6'd0, 16'(16'h200 + i));
            sb.push_back(mk(4'(i), 6'(i), 16'(16'h100 + i), 16'(16'h200 + i)));
        end
        tests++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d required 4", count); end
        tests++; if (inReady !== 1'b0) begin errors++; $display("FAIL fill_inReady: got %b required 0", inReady); end
        do_insert(4'hF, 6'd63, 1'b0, 6'd0, 16'hDEAD, 1'b0, 6'd0, 16'hDEAD);
        tests++; if (count !== 3'd4) begin errors++; $display("FAIL fill_5th_ignored: count=%0d required 4", count); end
        take_issue("fill_first");
        tests++; if (inReady !== 1'b1) begin errors++; $display("FAIL fill_inReady_after: got %b required 1", inReady); end
        tests++; if (count !== 3'd3) begin errors++; $display("FAIL fill_count_after: got %0d required 3", count); end
        repeat (3) take_issue("fill_drain");
        tests++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty: count=%0d required 0", count); end
    endtask

    task automatic test_age();
        do_insert(4'd1, 6'd3, 1'b1, 6'd9, 16'h0000, 1'b0, 6'd0, 16'h0033);
        do_insert(4'd2, 6'd5, 1'b0, 6'd0, 16'h0051, 1'b0, 6'd0, 16'h0052);
        do_insert(4'd3, 6'd7, 1'b0, 6'd0, 16'h0071, 1'b0, 6'd0, 16'h0072);
        sb.push_back(mk(4'd2, 6'd5, 16'h0051, 16'h0052));
        sb.push_back(mk(4'd3, 6'd7, 16'h0071, 16'h0072));
        take_issue("age_rob5");
        take_issue("age_rob7");
        tests++; if (outValid !== 1'b0) begin errors++; $display("FAIL age_waiting: outValid=%b required 0", outValid); end
        fwdValid = 2'b01; fwdTag = {6'd0, 6'd9}; fwdData = {16'h0, 16'h1234};
        tick();
        fwdValid = 2'b00;
        tests++; if (outValid !== 1'b1) begin errors++; $display("FAIL age_wake_latency: outValid=%b required 1", outValid); end
        sb.push_back(mk(4'd1, 6'd3, 16'h1234, 16'h0033));
        take_issue("age_rob3");
    endtask

    task automatic test_capture();
        fwdValid = 2'b10; fwdTag = {6'd12, 6'd0}; fwdData = {16'hBEEF, 16'h0};
        do_insert(4'd6, 6'd20, 1'b0, 6'd0, 16'h0AAA, 1'b1, 6'd12, 16'h0000);
        fwdValid = 2'b00;
        tests++; if (outValid !== 1'b1) begin errors++; $display("FAIL capture_ready: outValid=%b required 1", outValid); end
        sb.push_back(mk(4'd6, 6'd20, 16'h0AAA, 16'hBEEF));
        take_issue("capture_valB");
    endtask

    task automatic test_priority();
        do_insert(4'd7, 6'd21, 1'b1, 6'd4, 16'h0000, 1'b0, 6'd0, 16'h0777);
        fwdValid = 2'b11; fwdTag = {6'd4, 6'd4}; fwdData = {16'h0002, 16'h0001};
        tick();
        fwdValid = 2'b00;
        sb.push_back(mk(4'd7, 6'd21, 16'h0001, 16'h0777));
        take_issue("bus_priority");
    endtask

    task automatic test_back_to_back();
        logic [OPER_W-1:0] exp;
        do_insert(4'd1, 6'd10, 1'b0, 6'd0, 16'h00A1, 1'b0, 6'd0, 16'h00A2);
        do_insert(4'd2, 6'd11, 1'b0, 6'd0, 16'h00B1, 1'b0, 6'd0, 16'h00B2);
        sb.push_back(mk(4'd1, 6'd10, 16'h00A1, 16'h00A2));
        sb.push_back(mk(4'd2, 6'd11, 16'h00B1, 16'h00B2));
        tests++; if (count !== 3'd2) begin errors++; $display("FAIL simul_pre_count: got %0d required 2", count); end
        set_insert(4'd3, 6'd12, 1'b0, 6'd0, 16'h00C1, 1'b0, 6'd0, 16'h00C2);
        sb.push_back(mk(4'd3, 6'd12, 16'h00C1, 16'h00C2));
        exp = sb.pop_front();
        tests++; if (outValid !== 1'b1 || outOperation !== exp) begin
            errors++; $display("FAIL simul_issue: valid=%b op=%h required 1/%h", outValid, outOperation, exp);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0; inValid = 1'b0;
        tests++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d required 2", count); end
        take_issue("simul_rob11");
        take_issue("simul_rob12_last");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            do_insert(4'(i), 6'(30 + i), 1'b0, 6'd0, 16'(i), 1'b0, 6'd0, 16'(i));
        tests++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d required 3", count); end
        set_insert(4'd9, 6'd40, 1'b0, 6'd0, 16'h9, 1'b0, 6'd0, 16'h9);
        flush = 1'b1;
        #1;
        tests++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_comb_outValid: got %b required 0", outValid); end
        tick();
        flush = 1'b0; inValid = 1'b0;
        tests++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d required 0", count); end
        tests++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_outValid: got %b required 0", outValid); end
        sb.delete();
        do_insert(4'd1, 6'd50, 1'b0, 6'd0, 16'h1, 1'b0, 6'd0, 16'h1);
        do_insert(4'd2, 6'd51, 1'b1, 6'd2, 16'h2, 1'b0, 6'd0, 16'h2);
        tests++; if (count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d required 2", count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", count); end
        tests++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_inReady: got %b required 1", inReady); end
        tests++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid: got %b required 0", outValid); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inOp = '0; inRob = '0; inWaitA = 1'b0; inWaitB = 1'b0;
        inTagA = '0; inTagB = '0; inValA = '0; inValB = '0;
        fwdValid = '0; fwdTag = '0; fwdData = '0;
        test_reset();
        test_fill();
        test_age();
        test_capture();
        test_priority();
        test_back_to_back();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/reservation_station_param.md
RESERVATION_STATION_PARAM -- requirements
Module: reservation_station_param

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DEPTH, 8: number of entries, 2..16.
- NUM_FWD, 4: number of forwarding buses.
- TAG_W, 6: ROB tag width.
- DATA_W, 16: operand width.
- OP_W, 4: opcode width.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on its rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- flush, in, 1: discard all entries.
- inValid, in, 1: insert request.
- inReady, out, 1: a slot is free.
- inOp, in, OP_W: opcode.
- inRob, in, TAG_W: destination ROB tag.
- inWaitA, in, 1: operand A pending.
- inWaitB, in, 1: operand B pending.
- inTagA, in, TAG_W: ROB tag producing operand A.
- inTagB, in, TAG_W: ROB tag producing operand B.
- inValA, in, DATA_W: operand A value, meaningful when inWaitA=0.
- inValB, in, DATA_W: operand B value, meaningful when inWaitB=0.
- fwdValid, in, NUM_FWD: per-bus result valid.
- fwdTag, in, NUM_FWD*TAG_W: per-bus ROB tag; bus k occupies bits [k*TAG_W +: TAG_W].
- fwdData, in, NUM_FWD*DATA_W: per-bus result, packed the same way.
- outValid, out, 1: an entry is ready to issue.
- outReady, in, 1: consumer accepts the issue.
- outOperation, out, OP_W+TAG_W+2*DATA_W: {op, rob, valA, valB}.
- count, out, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-003 Each entry SHALL hold: occupied, op, rob, waitA, waitB, tagA, tagB, valA, valB, and its insertion age.
REQ-004 inReady SHALL equal (count < DEPTH), computed from registered state only; a slot freed by an issue in cycle N SHALL NOT be reusable until cycle N+1.
REQ-005 Insert rules:
- When inValid & inReady & !flush, the block SHALL write the lowest-index unoccupied entry at the clock edge.
- That entry SHALL become the youngest.
- count SHALL increment by 1.
REQ-006 Insert-time capture: if inWaitA=1 and some bus k has fwdValid[k]=1 with a tag equal to inTagA in the same cycle, the entry SHALL store waitA=0 and valA=that bus's data. Operand B SHALL behave identically.
REQ-007 Wake-up of stored entries: for every occupied entry with waitA=1 whose tagA matches a valid forward bus, the block SHALL clear waitA and load valA at the edge. Operand B SHALL behave identically.
REQ-008 If multiple valid buses match the same tag, the lowest-numbered bus SHALL win.
REQ-009 An entry SHALL be ready when it is occupied, waitA=0 and waitB=0, using registered state only. Wake-up-to-issue latency SHALL be 1 cycle.
REQ-010 Issue output:
- outValid SHALL be 1 when any entry is ready and flush=0.
- outOperation SHALL present the oldest ready entry by insertion order.
- When no entry is ready, outOperation SHALL be don't-care.
REQ-011 Issue handshake:
- When outValid & outReady, the selected entry SHALL be freed at the edge and count SHALL decrement.
- When outReady=0, the selection SHALL stay the oldest ready entry, so it can change only if an older entry becomes ready.
REQ-012 A simultaneous insert and issue SHALL leave count unchanged. The new entry SHALL be younger than all remaining entries.
REQ-013 flush=1 SHALL have these effects:
- All entries are cleared and count is 0 at the next edge.
- Insert, issue-free and wake-up are suppressed that cycle.
- outValid is forced to 0 combinationally.
REQ-014 Forward buses SHALL never write unoccupied entries. A matching forward SHALL have no effect on an operand whose wait bit is already 0.
REQ-015 count SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-016 On a rising clk edge with rst_n=0, the block SHALL clear all entries, and reset SHALL take priority over flush, insert and issue.
REQ-017 After reset: count=0, inReady=1, outValid=0.
REQ-018 Entry payload fields SHALL NOT need reset; only the occupied bits and age state SHALL be reset.

Verification
REQ-019 The bench (DEPTH=4, NUM_FWD=2, TAG_W=6, DATA_W=16) SHALL cover the following directed scenarios:
- Fill and full: insert 4 ready ops with outReady=0 -> count=4, inReady=0. A 5th insert is ignored. One accept -> inReady=1 on the next cycle.
- Age order: insert rob 3 (waitA, tagA=9), then rob 5 (ready), then rob 7 (ready) -> issues rob 5 then rob 7. A forward of tag 9 with 0x1234 -> rob 3 issues one cycle later with valA=0x1234.
- Insert-time capture: insert inWaitB=1, inTagB=12 while bus 1 carries tag 12, data 0xBEEF -> outValid=1 next cycle with valB=0xBEEF.
- Bus priority: bus 0 and bus 1 both carry tag 4, with data 0x0001 and 0x0002 -> the waiting operand receives 0x0001.
- Simultaneous: count=2, with insert and accept in the same cycle -> count stays 2 and the inserted op issues last.
- Flush and reset: flush with count=3 and inValid=1 -> count=0 and outValid=0 next cycle. rst_n=0 with flush=0 and count=2 -> count=0 and inReady=1.
